pwm_deadtime: RTL and testbench

- Downstream stage of the PWM generator: consumes its single-ended pwm_out and produces a complementary high-side/low-side gate-drive pair.
- Inserts a programmable dead band on every transition so the two outputs are never high together.
- Adds an enable, plus a latched fault shutdown with explicit clear.
- Same clock domain as the PWM generator, so no input synchroniser.

---
 rtl/pwm_deadtime.sv | 136 +++++++++++++
 tb/tb_pwm_deadtime.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage with programmable dead band.
// Takes the single-ended PWM stream and produces a high-side/low-side pair.
// The two outputs are never high together. A latched fault forces both
// outputs off until it is explicitly cleared.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// OFF      | disabled or just out of fault, both outputs low
// DT_HI    | dead band before turning the high side on
// HI_ON    | high side driven
// DT_LO    | dead band before turning the low side on
// LO_ON    | low side driven
// FAULT    | latched shutdown, waits for fault=0 and fault_clr=1
module pwm_deadtime #(
  parameter int DT_BITS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               pwm_in,
  input  logic [DT_BITS-1:0] dead_time,
  input  logic               fault,
  input  logic               fault_clr,
  output logic               hs_out,
  output logic               ls_out,
  output logic               dt_active,
  output logic               fault_flag
);

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_DT_HI = 3'd1;
  localparam logic [2:0] ST_HI_ON = 3'd2;
  localparam logic [2:0] ST_DT_LO = 3'd3;
  localparam logic [2:0] ST_LO_ON = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam logic [DT_BITS-1:0] CNT_ONE  = {{(DT_BITS-1){1'b0}}, 1'b1};
  localparam logic [DT_BITS-1:0] CNT_ZERO = '0;

  logic [2:0]         state_q, state_d;
  logic [DT_BITS-1:0] cnt_q, cnt_d;
  logic               hs_q, hs_d;
  logic               ls_q, ls_d;
  logic               dt_active_q, dt_active_d;
  logic               fault_flag_q, fault_flag_d;

  // Counter reload value: a dead band of D cycles counts D-1 down to 0.
  // A programmed value of 0 behaves as 1, i.e. reload 0.
  logic [DT_BITS-1:0] cnt_load;
  logic               cnt_zero;
  logic               next_is_dt;

  assign cnt_load = (dead_time == CNT_ZERO) ? CNT_ZERO : (dead_time - CNT_ONE);
  assign cnt_zero = (cnt_q == CNT_ZERO);

  // Next-state selection: fault first, then fault recovery, then enable,
  // then the normal transition/dead-band sequencing.
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (fault_clr) begin
        state_d = ST_OFF;
      end
    end else if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:   state_d = pwm_in ? ST_DT_HI : ST_DT_LO;
        ST_DT_HI: begin
          // Losing the request mid-band returns to the low side, which
          // is safe because the high side was never switched on.
          if (!pwm_in)       state_d = ST_LO_ON;
          else if (cnt_zero) state_d = ST_HI_ON;
        end
        ST_HI_ON: if (!pwm_in) state_d = ST_DT_LO;
        ST_DT_LO: begin
          if (pwm_in)        state_d = ST_HI_ON;
          else if (cnt_zero) state_d = ST_LO_ON;
        end
        ST_LO_ON: if (pwm_in) state_d = ST_DT_HI;
        default:  state_d = ST_OFF;
      endcase
    end
  end

  // Dead-band counter: dead_time is sampled only on entry to a dead-band
  // state, so mid-interval changes wait for the next transition.
  assign next_is_dt = (state_d == ST_DT_HI) || (state_d == ST_DT_LO);

  always_comb begin
    cnt_d = CNT_ZERO;
    if (next_is_dt) begin
      if (state_d != state_q) begin
        cnt_d = cnt_load;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // Registered outputs decoded from the next state so they change on the
  // same edge as the state itself.
  always_comb begin
    hs_d         = (state_d == ST_HI_ON);
    ls_d         = (state_d == ST_LO_ON);
    dt_active_d  = next_is_dt;
    fault_flag_d = (state_d == ST_FAULT);
  end

  // State, counter and output flops with asynchronous reset to OFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_OFF;
      cnt_q        <= CNT_ZERO;
      hs_q         <= 1'b0;
      ls_q         <= 1'b0;
      dt_active_q  <= 1'b0;
      fault_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hs_q         <= hs_d;
      ls_q         <= ls_d;
      dt_active_q  <= dt_active_d;
      fault_flag_q <= fault_flag_d;
    end
  end

  assign hs_out     = hs_q;
  assign ls_out     = ls_q;
  assign dt_active  = dt_active_q;
  assign fault_flag = fault_flag_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: a cycle model built from the dead-band rules
// (gap length, requested side, fault latch) is checked against the DUT on
// every falling edge, and directed scenarios add literal expectations.
module tb_pwm_deadtime;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       pwm_in;
  logic [7:0] dead_time;
  logic       fault;
  logic       fault_clr;
  logic       hs_out;
  logic       ls_out;
  logic       dt_active;
  logic       fault_flag;

  int n_cmp = 0;
  int n_err = 0;

  pwm_deadtime #(.DT_BITS(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .dead_time (dead_time),
    .fault     (fault),
    .fault_clr (fault_clr),
    .hs_out    (hs_out),
    .ls_out    (ls_out),
    .dt_active (dt_active),
    .fault_flag(fault_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: on = side currently driven (0 none, 1 high, 2 low), gap = dead
  // cycles still to elapse before tgt is driven, run = enabled and active.
  typedef struct packed {
    logic       flt;
    logic       run;
    logic [1:0] on;
    logic [1:0] tgt;
    int         gap;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_next(mdl_t cur, logic en, logic pwm,
                                    logic flt, logic clr, logic [7:0] dt);
    mdl_t       nx;
    int         d;
    logic [1:0] want;
    nx   = cur;
    d    = (dt == 8'd0) ? 1 : int'(dt);
    want = pwm ? 2'd1 : 2'd2;
    if (flt) begin
      nx.flt = 1'b1; nx.run = 1'b0; nx.on = 2'd0; nx.gap = 0;
    end else if (cur.flt) begin
      if (clr) nx.flt = 1'b0;
    end else if (!en) begin
      nx.run = 1'b0; nx.on = 2'd0; nx.gap = 0;
    end else if (!cur.run) begin
      nx.run = 1'b1; nx.tgt = want; nx.gap = d; nx.on = 2'd0;
    end else if (cur.gap > 0) begin
      if (want != cur.tgt) begin
        nx.on = want; nx.gap = 0;
      end else begin
        nx.gap = cur.gap - 1;
        if (nx.gap == 0) nx.on = cur.tgt;
      end
    end else if (want != cur.on) begin
      nx.tgt = want; nx.on = 2'd0; nx.gap = d;
    end
    return nx;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else          m <= mdl_next(m, enable, pwm_in, fault, fault_clr, dead_time);
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_hs", hs_out, m.on == 2'd1);
    check("model_ls", ls_out, m.on == 2'd2);
    check("model_dt", dt_active, m.gap > 0);
    check("model_flt", fault_flag, m.flt);
    check("exclusive", hs_out & ls_out, 1'b0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; pwm_in = 1'b0; dead_time = 8'd5;
    fault = 1'b0; fault_clr = 1'b0;
    #1;
    check("rst_hs", hs_out, 1'b0);
    check("rst_ls", ls_out, 1'b0);
    check("rst_dt", dt_active, 1'b0);
    check("rst_flt", fault_flag, 1'b0);
    tick(2);
    reset_n = 1'b1;

    // Start-up from OFF into the low side with a 5-cycle band.
    enable = 1'b1;
    tick(1);
    check("s1_dt_first", dt_active, 1'b1);
    tick(4);
    check("s1_dt_last", dt_active, 1'b1);
    check("s1_ls_off", ls_out, 1'b0);
    tick(1);
    check("s1_ls_on", ls_out, 1'b1);
    check("s1_dt_done", dt_active, 1'b0);

    // Low -> high -> low transitions.
    pwm_in = 1'b1;
    tick(1);
    check("s2_ls_drop", ls_out, 1'b0);
    tick(4);
    check("s2_hs_k4", hs_out, 1'b0);
    tick(1);
    check("s2_hs_k5", hs_out, 1'b1);
    tick(3);
    pwm_in = 1'b0;
    tick(1);
    check("s2_hs_drop", hs_out, 1'b0);
    tick(4);
    check("s2_ls_m4", ls_out, 1'b0);
    tick(1);
    check("s2_ls_m5", ls_out, 1'b1);

    // dead_time=0 behaves as a single dead cycle.
    dead_time = 8'd0;
    pwm_in = 1'b1;
    tick(1);
    check("s3_dt0_gap", dt_active, 1'b1);
    tick(1);
    check("s3_dt0_hs", hs_out, 1'b1);
    pwm_in = 1'b0;
    tick(1);
    check("s3_dt0_gap2", dt_active, 1'b1);
    tick(1);
    check("s3_dt0_ls", ls_out, 1'b1);

    // Change dead_time mid-band: current gap keeps 5, next gap uses 2.
    dead_time = 8'd5;
    pwm_in = 1'b1;
    tick(2);
    dead_time = 8'd2;
    tick(3);
    check("s3_keep5_k4", hs_out, 1'b0);
    tick(1);
    check("s3_keep5_k5", hs_out, 1'b1);
    pwm_in = 1'b0;
    tick(2);
    check("s3_new2_k1", ls_out, 1'b0);
    tick(1);
    check("s3_new2_k2", ls_out, 1'b1);

    // Short pulse shorter than the band is suppressed.
    dead_time = 8'd5;
    pwm_in = 1'b1;
    tick(3);
    check("s4_no_hs", hs_out, 1'b0);
    pwm_in = 1'b0;
    tick(1);
    check("s4_ls_back", ls_out, 1'b1);
    check("s4_dt_off", dt_active, 1'b0);

    // Fault from HI_ON, clear ignored while fault held, then recovery.
    pwm_in = 1'b1;
    tick(6);
    check("s5_hs_on", hs_out, 1'b1);
    fault = 1'b1;
    tick(1);
    check("s5_flt_hs", hs_out, 1'b0);
    check("s5_flt_flag", fault_flag, 1'b1);
    fault_clr = 1'b1;
    tick(2);
    check("s5_clr_ignored", fault_flag, 1'b1);
    fault = 1'b0;
    tick(1);
    check("s5_cleared", fault_flag, 1'b0);
    check("s5_off_dt", dt_active, 1'b0);
    fault_clr = 1'b0;
    tick(1);
    check("s5_band", dt_active, 1'b1);
    tick(4);
    check("s5_hs_k4", hs_out, 1'b0);
    tick(1);
    check("s5_hs_k5", hs_out, 1'b1);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("s6_async_hs", hs_out, 1'b0);
    check("s6_async_dt", dt_active, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("s6_restart_dt", dt_active, 1'b1);
    tick(5);
    check("s6_restart_hs", hs_out, 1'b1);

    // enable=0 from HI_ON drops both outputs at the next edge.
    enable = 1'b0;
    tick(1);
    check("s6_dis_hs", hs_out, 1'b0);
    check("s6_dis_ls", ls_out, 1'b0);
    pwm_in = 1'b0;
    tick(2);
    pwm_in = 1'b1;
    tick(2);
    check("s6_dis_stay", hs_out, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
